phy1_rcv: RTL
=============

PHY1_RCV -- requirements
Module: phy1_rcv

Interface
REQ-001 SHALL have parameter MAC_ADDR, default 48'h00_1E_C9_00_00_01, station address accepted besides broadcast.
REQ-002 SHALL have parameter ADDR_W, default 11, buffer address width (2048 bytes).
REQ-003 SHALL have port clock125_rx  in  1  RGMII receive clock; the only clock.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port phy1_rx_dv  in  1  RX_CTL rising-edge sample, already de-DDR'd.
REQ-006 SHALL have port phy1_rx_err  in  1  RX_CTL rising XOR falling sample (receive error).
REQ-007 SHALL have port phy1_rx  in  8  received byte; [3:0] rising nibble, [7:4] falling nibble.
REQ-008 SHALL have ports ipmem_address out ADDR_W, ipmem_data out 8 and ipmem_wren out 1, the write port of ip_buffer.
REQ-009 SHALL have port frame_valid  out  1  buffer holds one complete accepted frame.
REQ-010 SHALL have ports frame_len out ADDR_W (bytes excluding FCS) and frame_type out 16 (EtherType, bytes 12-13).
REQ-011 SHALL have ports cpy_ready in 1 (consumer done, releases buffer) and drop_cnt out 8 (dropped frames).

Function
REQ-012 SHALL use states IDLE, PREAMBLE, DATA, HOLD and DROP.
REQ-013 IDLE: dv=1 with 8'h55 SHALL go to PREAMBLE; dv=1 with 8'hD5 SHALL go to DATA; dv=1 with any other byte SHALL go to DROP and count.
REQ-014 PREAMBLE: 8'h55 SHALL stay; 8'hD5 SHALL go to DATA; any other byte or dv=0 SHALL go to DROP and count.
REQ-015 DATA: each dv=1 byte SHALL be written at address count, with count starting at 0 after the SFD; registered write appears one cycle after sampling.
REQ-016 After byte 5, destination not equal to MAC_ADDR and not equal to FF:FF:FF:FF:FF:FF SHALL go to DROP, not counted.
REQ-017 rx_err=1 in DATA, or count reaching 2^ADDR_W-1, SHALL go to DROP and count.
REQ-018 dv falling in DATA with count<64 SHALL drop and count; otherwise, next cycle frame_valid=1, frame_len=count-4, frame_type latched, and state goes to HOLD.
REQ-019 HOLD: ipmem_wren=0; each dv 0->1 transition SHALL increment drop_cnt (busy drop).
REQ-020 HOLD with cpy_ready=1 SHALL clear frame_valid next cycle, then go to IDLE if dv=0 or to DROP without counting if dv=1.
REQ-021 DROP: ipmem_wren=0; SHALL return to IDLE on the first dv=0 cycle.
REQ-022 drop_cnt SHALL saturate at 255, with at most one increment per frame.
REQ-023 cpy_ready outside HOLD SHALL be ignored.

Reset
REQ-024 Reset SHALL set state IDLE and set ipmem_address, ipmem_data, ipmem_wren, frame_valid, frame_len, frame_type and drop_cnt to 0.
REQ-025 After reset mid-frame, the frame remainder SHALL be handled by IDLE rules: non-preamble byte goes to DROP, counted once.

Configuration
REQ-026 With PHY1_RX_CRC_EN defined, CRC-32 SHALL be computed over all DATA bytes, and a residue other than 32'hC704DD7B at dv fall SHALL drop and count with no added latency.
REQ-027 Without PHY1_RX_CRC_EN, the FCS SHALL be stored but not checked, and no CRC logic SHALL be present.

Structure
REQ-028 Package phy1_pkg SHALL hold the state enum, ETH_PREAMBLE 8'h55, ETH_SFD 8'hD5, MIN_FRAME 64, FCS_LEN 4, CRC_RESIDUE and BCAST_MAC.
REQ-029 Sub-module phy1_crc32 (byte-wide CRC-32 step, reflected, poly 32'h04C11DB7) SHALL be instantiated only under PHY1_RX_CRC_EN.

Verification
REQ-030 Valid frame: 7x55, D5, 60-byte frame to MAC_ADDR, type 0800, good FCS -> writes at addresses 0..63, frame_valid=1, frame_len=60, frame_type=16'h0800.
REQ-031 Dest 02:00:00:00:00:99 -> no writes after byte 5, frame_valid=0, drop_cnt unchanged; broadcast dest -> accepted.
REQ-032 Frame arrives during HOLD -> drop_cnt+1; cpy_ready pulse in mid-frame -> frame_valid=0, DROP until dv=0, then next frame accepted.
REQ-033 Runt (40 bytes), rx_err in byte 20, or 2100-byte frame -> each drop_cnt+1, frame_valid=0; 300 bad frames -> drop_cnt=255.
REQ-034 With PHY1_RX_CRC_EN, a one-bit FCS flip -> drop_cnt+1, frame_valid=0; without the macro, the same frame -> frame_valid=1.
REQ-035 rst asserted at byte 30, released at byte 40 -> all outputs 0, DROP until dv=0, drop_cnt=1, next frame accepted.

Source files
------------

// File: rtl/phy1_pkg.sv
// phy1_pkg -- shared types and constants for the PHY1 RGMII receive path.
//
// Contents:
//   rx_state_e   receive FSM states
//   ETH_*        preamble / SFD byte values
//   MIN_FRAME    smallest legal frame in bytes, FCS included
//   FCS_LEN      FCS length in bytes
//   CRC_*        CRC-32 polynomial, seed and good-frame residue (non-reflected form)
//   BCAST_MAC    broadcast destination address
//   bitrev32()   32-bit bit reversal, used to move between reflected/normal CRC forms

package phy1_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StData,
        StHold,
        StDrop
    } rx_state_e;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam int unsigned MIN_FRAME    = 64;
    localparam int unsigned FCS_LEN      = 4;
    localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;
    localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/phy1_crc32.sv
// phy1_crc32 -- one byte step of the Ethernet CRC-32 (reflected, LSB first).
//
// Ports:
//   crc_in   current CRC register (reflected form)
//   data     byte to fold in, bit 0 first on the wire
//   crc_out  CRC register after the byte
//
// Purely combinational; the caller owns the register and its seed.

module phy1_crc32
    import phy1_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = bitrev32(CRC_POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/phy1_rcv.sv
// phy1_rcv -- RGMII (already de-DDR'd) receive framer writing one frame into ip_buffer.
//
// Ports:
//   clock125_rx                   receive clock (only clock)
//   rst                           synchronous active-high reset
//   phy1_rx_dv / phy1_rx_err      RX_CTL data-valid and error samples
//   phy1_rx[7:0]                  received byte
//   ipmem_address/data/wren       registered write port of ip_buffer
//   frame_valid                   buffer holds one accepted frame
//   frame_len                     accepted length excluding FCS
//   frame_type                    EtherType of the accepted frame
//   cpy_ready                     consumer done, releases the buffer (only honoured in HOLD)
//   drop_cnt                      saturating count of dropped frames
//
// Build option: define PHY1_RX_CRC_EN to check the FCS; otherwise the FCS is
// stored in the buffer unchecked and no CRC hardware is built.

module phy1_rcv
    import phy1_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h00_1E_C9_00_00_01,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic              clock125_rx,
    input  logic              rst,
    input  logic              phy1_rx_dv,
    input  logic              phy1_rx_err,
    input  logic [7:0]        phy1_rx,
    output logic [ADDR_W-1:0] ipmem_address,
    output logic [7:0]        ipmem_data,
    output logic              ipmem_wren,
    output logic              frame_valid,
    output logic [ADDR_W-1:0] frame_len,
    output logic [15:0]       frame_type,
    input  logic              cpy_ready,
    output logic [7:0]        drop_cnt
);

    localparam logic [ADDR_W-1:0] CNT_MAX   = '1;
    localparam logic [ADDR_W-1:0] MIN_LEN   = ADDR_W'(MIN_FRAME);
    localparam logic [ADDR_W-1:0] FCS_W     = ADDR_W'(FCS_LEN);
    localparam logic [ADDR_W-1:0] DEST_LAST = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] TYPE_HI   = ADDR_W'(12);
    localparam logic [ADDR_W-1:0] TYPE_LO   = ADDR_W'(13);

    rx_state_e         state_q;
    logic [ADDR_W-1:0] count_q;
    logic [39:0]       dest_q;   // destination bytes 0..4, byte 5 is taken live
    logic [15:0]       type_q;
    logic              dv_q;

    logic [47:0] dest_full;
    logic        dest_ok;
    logic        crc_bad;
    logic        count_drop;

    assign dest_full = {dest_q, phy1_rx};
    assign dest_ok   = (dest_full == MAC_ADDR) || (dest_full == BCAST_MAC);

`ifdef PHY1_RX_CRC_EN
    logic [31:0] crc_q;
    logic [31:0] crc_next;

    phy1_crc32 u_crc (
        .crc_in  (crc_q),
        .data    (phy1_rx),
        .crc_out (crc_next)
    );

    // Register runs in reflected form; the residue constant is in normal form.
    assign crc_bad = (bitrev32(crc_q) != CRC_RESIDUE);

    always_ff @(posedge clock125_rx) begin
        if (rst || (state_q != StData)) begin
            crc_q <= CRC_INIT;
        end else if (phy1_rx_dv) begin
            crc_q <= crc_next;
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

    // One counted drop per frame: every branch that sets this also leaves the
    // frame-receiving states, so the same frame cannot be counted twice.
    always_comb begin
        count_drop = 1'b0;
        case (state_q)
            StIdle: begin
                count_drop = phy1_rx_dv && (phy1_rx != ETH_PREAMBLE) && (phy1_rx != ETH_SFD);
            end
            StPreamble: begin
                count_drop = !phy1_rx_dv ||
                             ((phy1_rx != ETH_PREAMBLE) && (phy1_rx != ETH_SFD));
            end
            StData: begin
                if (phy1_rx_dv) begin
                    count_drop = phy1_rx_err || (count_q == CNT_MAX);
                end else begin
                    count_drop = (count_q < MIN_LEN) || crc_bad;
                end
            end
            StHold: begin
                count_drop = phy1_rx_dv && !dv_q;
            end
            default: count_drop = 1'b0;
        endcase
    end

    always_ff @(posedge clock125_rx) begin
        if (rst) begin
            state_q       <= StIdle;
            count_q       <= '0;
            dest_q        <= '0;
            type_q        <= '0;
            dv_q          <= 1'b0;
            ipmem_address <= '0;
            ipmem_data    <= '0;
            ipmem_wren    <= 1'b0;
            frame_valid   <= 1'b0;
            frame_len     <= '0;
            frame_type    <= '0;
            drop_cnt      <= '0;
        end else begin
            dv_q       <= phy1_rx_dv;
            ipmem_wren <= 1'b0;
            if (count_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            case (state_q)
                StIdle, StPreamble: begin
                    if (phy1_rx_dv && (phy1_rx == ETH_PREAMBLE)) begin
                        state_q <= StPreamble;
                    end else if (phy1_rx_dv && (phy1_rx == ETH_SFD)) begin
                        state_q <= StData;
                        count_q <= '0;
                    end else if (count_drop) begin
                        state_q <= StDrop;
                    end
                end
                StData: begin
                    if (phy1_rx_dv) begin
                        if (count_drop) begin
                            state_q <= StDrop;
                        end else begin
                            ipmem_wren    <= 1'b1;
                            ipmem_address <= count_q;
                            ipmem_data    <= phy1_rx;
                            count_q       <= count_q + 1'b1;
                            if (count_q < DEST_LAST) begin
                                dest_q <= {dest_q[31:0], phy1_rx};
                            end
                            // Foreign unicast: the byte is stored, the rest is not.
                            if ((count_q == DEST_LAST) && !dest_ok) begin
                                state_q <= StDrop;
                            end
                            if (count_q == TYPE_HI) begin
                                type_q[15:8] <= phy1_rx;
                            end
                            if (count_q == TYPE_LO) begin
                                type_q[7:0] <= phy1_rx;
                            end
                        end
                    end else if (count_drop) begin
                        state_q <= StIdle;
                    end else begin
                        frame_valid <= 1'b1;
                        frame_len   <= count_q - FCS_W;
                        frame_type  <= type_q;
                        state_q     <= StHold;
                    end
                end
                StHold: begin
                    if (cpy_ready) begin
                        frame_valid <= 1'b0;
                        state_q     <= phy1_rx_dv ? StDrop : StIdle;
                    end
                end
                StDrop: begin
                    if (!phy1_rx_dv) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
